// File: rtl/core_uart_pkg.sv
// Shared definitions for the APB UART: register offsets, parity encoding,
// TX/RX FSM state encodings, STATUS bit positions and the parity helper.
package core_uart_pkg;

    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_CTRL3  = 5'h14;

    localparam int ST_TXRDY = 0;
    localparam int ST_RXRDY = 1;
    localparam int ST_PERR  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_FERR  = 4;

    typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_e;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    // Parity bit that goes on the wire for the given data; only the low
    // 7 bits take part in 7-bit frames.
    function automatic logic par_bit(input logic [7:0] d, input logic bit8, input parity_e p);
        logic x;
        x = bit8 ? ^d : ^d[6:0];
        return (p == PAR_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversample tick generator.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   baud_i        : integer divisor, tick period = baud_i+1 cycles
//   frac_i        : number of ticks out of every 8 stretched by one cycle
//   frac_en_i     : enables the fractional stretch
//   tick_o        : one-cycle pulse per oversample tick
module uart_baud_gen (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [12:0] baud_i,
    input  logic [2:0]  frac_i,
    input  logic        frac_en_i,
    output logic        tick_o
);
    logic [13:0] cnt_q, cnt_d, limit;
    logic [2:0]  idx_q, idx_d;

    assign limit  = {1'b0, baud_i} + ((frac_en_i && (idx_q < frac_i)) ? 14'd1 : 14'd0);
    // >= so a divisor that shrinks under a running count still wraps at once
    assign tick_o = (cnt_q >= limit);

    always_comb begin
        cnt_d = cnt_q + 14'd1;
        idx_d = idx_q;
        if (tick_o) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end
endmodule

// File: rtl/core_uart_apb.sv
// APB-slave UART with single-byte TX and RX holding registers.
//   PCLK, PRESETN        : clock, synchronous active-low reset
//   PSEL..PWDATA         : APB request; PRDATA/PREADY/PSLVERR response
//   TXRDY, RXRDY         : holding register empty / full
//   PARITY_ERR, FRAMING_ERR, OVERFLOW : sticky receive errors, cleared by RX data read
//   RX, TX               : serial pins, TX idles high
module core_uart_apb
    import core_uart_pkg::*;
#(
    parameter int FAMILY            = 0,
    parameter int TX_FIFO           = 0,
    parameter int RX_FIFO           = 0,
    parameter int FIXEDMODE         = 0,
    parameter int BAUD_VALUE        = 1,
    parameter int PRG_BIT8          = 1,
    parameter int PRG_PARITY        = 0,
    parameter int RX_LEGACY_MODE    = 0,
    parameter int BAUD_VAL_FRCTN    = 0,
    parameter int BAUD_VAL_FRCTN_EN = 0
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [4:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    output logic       TXRDY,
    output logic       RXRDY,
    output logic       PARITY_ERR,
    output logic       FRAMING_ERR,
    output logic       OVERFLOW,
    input  logic       RX,
    output logic       TX
);
    localparam logic [12:0] BAUD_RST = 13'(BAUD_VALUE);
    localparam logic        BIT8_RST = (PRG_BIT8 != 0);
    localparam logic        PEN_RST  = (PRG_PARITY != 0);
    localparam logic        ODD_RST  = (PRG_PARITY == 2);
    localparam logic [2:0]  FRAC_RST = 3'(BAUD_VAL_FRCTN);
    localparam logic        FRAC_EN  = (BAUD_VAL_FRCTN_EN != 0);

    // Technology tag and FIFO depths have no functional effect here.
    logic unused_cfg;
    assign unused_cfg = (FAMILY != 0) | (TX_FIFO != 0) | (RX_FIFO != 0);

    logic wr_en, rd_acc, ctrl_wr, rd_clr, tick;
    assign wr_en   = PSEL & PENABLE & PWRITE;
    assign rd_acc  = PSEL & PENABLE & ~PWRITE;
    assign ctrl_wr = wr_en && (FIXEDMODE == 0);
    assign rd_clr  = rd_acc && (PADDR == ADDR_RXDATA);

    // ---------------- control registers ----------------
    logic [12:0] baud_q, baud_act_q;
    logic [2:0]  frac_q, frac_act_q;
    logic        bit8_q, pen_q, odd_q;
    parity_e     cfg_par;

    assign cfg_par = !pen_q ? PAR_NONE : (odd_q ? PAR_ODD : PAR_EVEN);

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            baud_q <= BAUD_RST;
            bit8_q <= BIT8_RST;
            pen_q  <= PEN_RST;
            odd_q  <= ODD_RST;
            frac_q <= FRAC_RST;
        end else if (ctrl_wr) begin
            case (PADDR)
                ADDR_CTRL1: baud_q[7:0] <= PWDATA;
                ADDR_CTRL2: begin
                    bit8_q       <= PWDATA[0];
                    pen_q        <= PWDATA[1];
                    odd_q        <= PWDATA[2];
                    baud_q[12:8] <= PWDATA[7:3];
                end
                ADDR_CTRL3: frac_q <= PWDATA[2:0];
                default: ;
            endcase
        end
    end

    tx_state_e tx_state_q, tx_state_d;
    rx_state_e rx_state_q, rx_state_d;

    // The shared divisor only follows the registers while both directions
    // are idle, so a frame in flight never changes speed.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            baud_act_q <= BAUD_RST;
            frac_act_q <= FRAC_RST;
        end else if (tx_state_q == TX_IDLE && rx_state_q == RX_IDLE) begin
            baud_act_q <= baud_q;
            frac_act_q <= frac_q;
        end
    end

    uart_baud_gen u_baud (
        .clk_i    (PCLK),
        .rst_ni   (PRESETN),
        .baud_i   (baud_act_q),
        .frac_i   (frac_act_q),
        .frac_en_i(FRAC_EN),
        .tick_o   (tick)
    );

    // ---------------- transmitter ----------------
    logic [7:0] thr_q, thr_d, tx_sh_q, tx_sh_d;
    logic [3:0] tx_tcnt_q, tx_tcnt_d;
    logic [2:0] tx_idx_q, tx_idx_d;
    logic       txrdy_q, txrdy_d, tx_pend_q, tx_pend_d, tx_q, tx_d;
    logic       tx_bit8_q, tx_bit8_d, tx_pen_q, tx_pen_d, tx_pbit_q, tx_pbit_d;
    logic       tx_bit_end;

    assign tx_bit_end = tick && (tx_tcnt_q == 4'd15);

    always_comb begin
        tx_state_d = tx_state_q;
        thr_d      = thr_q;
        txrdy_d    = txrdy_q;
        tx_sh_d    = tx_sh_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_idx_d   = tx_idx_q;
        tx_pend_d  = tx_pend_q;
        tx_bit8_d  = tx_bit8_q;
        tx_pen_d   = tx_pen_q;
        tx_pbit_d  = tx_pbit_q;
        tx_d       = tx_q;
        if (wr_en && PADDR == ADDR_TXDATA && txrdy_q) begin
            thr_d   = PWDATA;
            txrdy_d = 1'b0;
        end
        if (tick) tx_tcnt_d = tx_tcnt_q + 4'd1;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                // Shifter empty: take the holding byte (and its frame format)
                // now, then wait for a tick boundary to start the frame.
                if (!tx_pend_q && !txrdy_q) begin
                    tx_sh_d   = thr_q;
                    tx_pend_d = 1'b1;
                    txrdy_d   = 1'b1;
                    tx_bit8_d = bit8_q;
                    tx_pen_d  = (cfg_par != PAR_NONE);
                    tx_pbit_d = par_bit(thr_q, bit8_q, cfg_par);
                end else if (tx_pend_q && tick) begin
                    tx_pend_d  = 1'b0;
                    tx_state_d = TX_START;
                    tx_tcnt_d  = '0;
                    tx_d       = 1'b0;
                end
            end
            TX_START: if (tx_bit_end) begin
                tx_state_d = TX_DATA;
                tx_idx_d   = '0;
                tx_d       = tx_sh_q[0];
            end
            TX_DATA: if (tx_bit_end) begin
                tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                tx_idx_d = tx_idx_q + 3'd1;
                if (tx_idx_q == (tx_bit8_q ? 3'd7 : 3'd6)) begin
                    tx_state_d = tx_pen_q ? TX_PARITY : TX_STOP;
                    tx_d       = tx_pen_q ? tx_pbit_q : 1'b1;
                end else begin
                    tx_d = tx_sh_q[1];
                end
            end
            TX_PARITY: if (tx_bit_end) begin
                tx_state_d = TX_STOP;
                tx_d       = 1'b1;
            end
            TX_STOP: if (tx_bit_end) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            tx_state_q <= TX_IDLE;
            thr_q      <= '0;
            txrdy_q    <= 1'b1;
            tx_sh_q    <= '0;
            tx_tcnt_q  <= '0;
            tx_idx_q   <= '0;
            tx_pend_q  <= 1'b0;
            tx_bit8_q  <= BIT8_RST;
            tx_pen_q   <= 1'b0;
            tx_pbit_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            thr_q      <= thr_d;
            txrdy_q    <= txrdy_d;
            tx_sh_q    <= tx_sh_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_pend_q  <= tx_pend_d;
            tx_bit8_q  <= tx_bit8_d;
            tx_pen_q   <= tx_pen_d;
            tx_pbit_q  <= tx_pbit_d;
            tx_q       <= tx_d;
        end
    end

    // ---------------- receiver ----------------
    logic       rx_s1_q, rx_s2_q, rx_s3_q;
    logic [7:0] rbr_q, rbr_d, rx_sh_q, rx_sh_d, rx_byte;
    logic [3:0] rx_tcnt_q, rx_tcnt_d;
    logic [2:0] rx_idx_q, rx_idx_d;
    logic [1:0] rx_smp_q, rx_smp_d;
    parity_e    rx_par_q, rx_par_d;
    logic       rx_bit8_q, rx_bit8_d, rx_perr_q, rx_perr_d;
    logic       rxrdy_q, rxrdy_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic       rx_fall, rx_mid, rx_bit_end, rx_maj, rx_bit;

    assign rx_fall    = rx_s3_q & ~rx_s2_q;
    assign rx_mid     = tick && (rx_tcnt_q == 4'd9);
    assign rx_bit_end = tick && (rx_tcnt_q == 4'd15);
    // smp[0]/smp[1] hold the line at ticks 7/8; the current value is tick 9
    assign rx_maj  = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_s2_q) | (rx_smp_q[1] & rx_s2_q);
    assign rx_bit  = (RX_LEGACY_MODE != 0) ? rx_smp_q[1] : rx_maj;
    // 7-bit frames leave the data in the upper seven shifter bits
    assign rx_byte = rx_bit8_q ? rx_sh_q : {1'b0, rx_sh_q[7:1]};

    always_comb begin
        rx_state_d = rx_state_q;
        rbr_d      = rbr_q;
        rx_sh_d    = rx_sh_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_idx_d   = rx_idx_q;
        rx_smp_d   = rx_smp_q;
        rx_par_d   = rx_par_q;
        rx_bit8_d  = rx_bit8_q;
        rx_perr_d  = rx_perr_q;
        rxrdy_d    = rxrdy_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovf_d      = ovf_q;
        if (tick) rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (tick && rx_tcnt_q == 4'd7) rx_smp_d[0] = rx_s2_q;
        if (tick && rx_tcnt_q == 4'd8) rx_smp_d[1] = rx_s2_q;
        if (rd_clr) begin
            rxrdy_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
        end
        case (rx_state_q)
            RX_IDLE: begin
                // A line still low at a tick re-arms after a broken frame.
                if (rx_fall || (tick && !rx_s2_q)) begin
                    rx_state_d = RX_START;
                    rx_tcnt_d  = '0;
                    rx_idx_d   = '0;
                    rx_sh_d    = '0;
                    rx_perr_d  = 1'b0;
                    rx_bit8_d  = bit8_q;
                    rx_par_d   = cfg_par;
                end
            end
            RX_START: begin
                if (tick && rx_tcnt_q == 4'd8 && rx_s2_q) rx_state_d = RX_IDLE;
                else if (rx_bit_end) rx_state_d = RX_DATA;
            end
            RX_DATA: begin
                if (rx_mid) rx_sh_d = {rx_bit, rx_sh_q[7:1]};
                if (rx_bit_end) begin
                    rx_idx_d = rx_idx_q + 3'd1;
                    if (rx_idx_q == (rx_bit8_q ? 3'd7 : 3'd6))
                        rx_state_d = (rx_par_q != PAR_NONE) ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (rx_mid) rx_perr_d = (rx_bit != par_bit(rx_byte, rx_bit8_q, rx_par_q));
                if (rx_bit_end) rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                if (rx_mid) begin
                    rx_state_d = RX_IDLE;
                    if (rx_perr_q) perr_d = 1'b1;
                    if (!rx_bit) ferr_d = 1'b1;
                    // A same-cycle read clear frees the register for this byte.
                    if (rxrdy_q && !rd_clr) begin
                        ovf_d = 1'b1;
                    end else begin
                        rbr_d   = rx_byte;
                        rxrdy_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rbr_q      <= '0;
            rx_sh_q    <= '0;
            rx_tcnt_q  <= '0;
            rx_idx_q   <= '0;
            rx_smp_q   <= 2'b11;
            rx_par_q   <= PAR_NONE;
            rx_bit8_q  <= BIT8_RST;
            rx_perr_q  <= 1'b0;
            rxrdy_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rx_s1_q    <= RX;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rbr_q      <= rbr_d;
            rx_sh_q    <= rx_sh_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_smp_q   <= rx_smp_d;
            rx_par_q   <= rx_par_d;
            rx_bit8_q  <= rx_bit8_d;
            rx_perr_q  <= rx_perr_d;
            rxrdy_q    <= rxrdy_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
        end
    end

    // ---------------- read mux and outputs ----------------
    logic [7:0] status;
    always_comb begin
        status           = '0;
        status[ST_TXRDY] = txrdy_q;
        status[ST_RXRDY] = rxrdy_q;
        status[ST_PERR]  = perr_q;
        status[ST_OVF]   = ovf_q;
        status[ST_FERR]  = ferr_q;
    end

    always_comb begin
        PRDATA = 8'h00;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                ADDR_RXDATA: PRDATA = rbr_q;
                ADDR_CTRL1:  PRDATA = baud_q[7:0];
                ADDR_CTRL2:  PRDATA = {baud_q[12:8], odd_q, pen_q, bit8_q};
                ADDR_STATUS: PRDATA = status;
                ADDR_CTRL3:  PRDATA = {5'b0, frac_q};
                default:     PRDATA = 8'h00;
            endcase
        end
    end

    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign TXRDY       = txrdy_q;
    assign RXRDY       = rxrdy_q;
    assign PARITY_ERR  = perr_q;
    assign FRAMING_ERR = ferr_q;
    assign OVERFLOW    = ovf_q;
    assign TX          = tx_q;
endmodule

// File: tb/tb_core_uart_apb.sv
// Bench: two UARTs, DUT0 TX feeding DUT1 RX (RX of DUT1 can be forced).
module tb_core_uart_apb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn [2], psel [2], penable [2], pwrite [2];
    logic [4:0] paddr [2];
    logic [7:0] pwdata [2], prdata [2];
    logic       pready [2], pslverr [2], txrdy [2], rxrdy [2], perr [2], ferr [2], ovf [2], tx [2];
    logic       rx0, force_rx, force_val, rx1;

    assign rx1 = force_rx ? force_val : tx[0];

    core_uart_apb u_dut0 (
        .PCLK(clk), .PRESETN(rstn[0]), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
        .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
        .PSLVERR(pslverr[0]), .TXRDY(txrdy[0]), .RXRDY(rxrdy[0]), .PARITY_ERR(perr[0]),
        .FRAMING_ERR(ferr[0]), .OVERFLOW(ovf[0]), .RX(rx0), .TX(tx[0]));

    core_uart_apb u_dut1 (
        .PCLK(clk), .PRESETN(rstn[1]), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
        .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
        .PSLVERR(pslverr[1]), .TXRDY(txrdy[1]), .RXRDY(rxrdy[1]), .PARITY_ERR(perr[1]),
        .FRAMING_ERR(ferr[1]), .OVERFLOW(ovf[1]), .RX(rx1), .TX(tx[1]));

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;
    vec_t vt [16];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic apb_wr(input int d, input logic [4:0] a, input logic [7:0] v);
        @(posedge clk); #1;
        psel[d] = 1'b1; pwrite[d] = 1'b1; paddr[d] = a; pwdata[d] = v; penable[d] = 1'b0;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        @(posedge clk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
    endtask

    task automatic apb_rd(input int d, input logic [4:0] a, output logic [7:0] v);
        @(posedge clk); #1;
        psel[d] = 1'b1; pwrite[d] = 1'b0; paddr[d] = a; penable[d] = 1'b0;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        v = prdata[d];
        @(posedge clk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic rd_chk(input int d, input logic [4:0] a, input logic [7:0] exp, input string name);
        logic [7:0] v;
        apb_rd(d, a, v);
        chk(name, v, exp);
    endtask

    // Waits on DUT1 RXRDY (or OVERFLOW) with a cycle budget.
    task automatic wait_rx(input bit want_ovf, input int budget, input string name);
        int n = 0;
        while (((want_ovf ? ovf[1] : rxrdy[1]) !== 1'b1) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: flag not seen after %0d cycles, expected 1", name, budget);
        end
    endtask

    task automatic do_reset();
        rstn[0] = 1'b0; rstn[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn[0] = 1'b1; rstn[1] = 1'b1;
    endtask

    initial begin
        logic [7:0] v;
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0;
        end
        rx0 = 1'b1; force_rx = 1'b0; force_val = 1'b1;

        vt[0]  = '{1'b0, 5'h08, 8'h00, 8'h01};
        vt[1]  = '{1'b0, 5'h0C, 8'h00, 8'h01};
        vt[2]  = '{1'b0, 5'h10, 8'h00, 8'h01};
        vt[3]  = '{1'b0, 5'h04, 8'h00, 8'h00};
        vt[4]  = '{1'b0, 5'h14, 8'h00, 8'h00};
        vt[5]  = '{1'b0, 5'h00, 8'h00, 8'h00};
        vt[6]  = '{1'b1, 5'h08, 8'h34, 8'h00};
        vt[7]  = '{1'b0, 5'h08, 8'h00, 8'h34};
        vt[8]  = '{1'b1, 5'h0C, 8'hA9, 8'h00};
        vt[9]  = '{1'b0, 5'h0C, 8'h00, 8'hA9};
        vt[10] = '{1'b1, 5'h14, 8'hFF, 8'h00};
        vt[11] = '{1'b0, 5'h14, 8'h00, 8'h07};
        vt[12] = '{1'b1, 5'h18, 8'h5A, 8'h00};
        vt[13] = '{1'b0, 5'h18, 8'h00, 8'h00};
        vt[14] = '{1'b1, 5'h10, 8'hFF, 8'h00};
        vt[15] = '{1'b0, 5'h10, 8'h00, 8'h01};

        do_reset();
        @(posedge clk); #1;
        chk("rst_pins", {3'b0, txrdy[0], rxrdy[0], perr[0], ovf[0], ferr[0]}, 8'h10);
        chk("rst_tx", {7'b0, tx[0]}, 8'h01);
        chk("prdata_idle", prdata[0], 8'h00);
        chk("pready_pslverr", {6'b0, pready[0], pslverr[0]}, 8'h02);

        // Register table on DUT0
        for (int i = 0; i < 16; i++) begin
            if (vt[i].wr) apb_wr(0, vt[i].addr, vt[i].wdata);
            else rd_chk(0, vt[i].addr, vt[i].exp, $sformatf("vec%0d", i));
        end
        do_reset();

        // Loopback 8N1, baud 1
        apb_wr(0, 5'h00, 8'h55);
        wait_rx(1'b0, 2000, "lb_wait");
        rd_chk(1, 5'h10, 8'h03, "lb_status");
        rd_chk(1, 5'h04, 8'h55, "lb_data");
        rd_chk(1, 5'h10, 8'h01, "lb_status_clr");
        repeat (100) @(posedge clk);
        #1;
        chk("lb_tx_idle", {6'b0, txrdy[0], tx[0]}, 8'h03);

        // Even parity, then receiver switched to odd
        apb_wr(0, 5'h0C, 8'h03);
        apb_wr(1, 5'h0C, 8'h03);
        apb_wr(0, 5'h00, 8'hA3);
        wait_rx(1'b0, 2000, "par_even_wait");
        rd_chk(1, 5'h10, 8'h03, "par_even_status");
        rd_chk(1, 5'h04, 8'hA3, "par_even_data");
        apb_wr(1, 5'h0C, 8'h07);
        apb_wr(0, 5'h00, 8'hA3);
        wait_rx(1'b0, 2000, "par_odd_wait");
        rd_chk(1, 5'h10, 8'h07, "par_odd_status");
        rd_chk(1, 5'h04, 8'hA3, "par_odd_data");
        rd_chk(1, 5'h10, 8'h01, "par_odd_clr");

        // Back-to-back writes: third write lands while TXRDY=0 and is dropped
        apb_wr(0, 5'h0C, 8'h01);
        apb_wr(1, 5'h0C, 8'h01);
        repeat (100) @(posedge clk);
        apb_wr(0, 5'h00, 8'h01);
        apb_wr(0, 5'h00, 8'h02);
        apb_wr(0, 5'h00, 8'h03);
        rd_chk(0, 5'h10, 8'h00, "b2b_txrdy_low");
        wait_rx(1'b0, 2000, "b2b_wait1");
        rd_chk(1, 5'h04, 8'h01, "b2b_data1");
        wait_rx(1'b0, 2000, "b2b_wait2");
        rd_chk(1, 5'h04, 8'h02, "b2b_data2");
        repeat (800) @(posedge clk);
        #1;
        chk("b2b_dropped", {7'b0, rxrdy[1]}, 8'h00);
        rd_chk(0, 5'h10, 8'h01, "b2b_txrdy_high");

        // Overflow: two bytes, no read in between
        apb_wr(0, 5'h00, 8'h11);
        apb_wr(0, 5'h00, 8'h22);
        wait_rx(1'b1, 3000, "ovf_wait");
        rd_chk(1, 5'h10, 8'h0B, "ovf_status");
        rd_chk(1, 5'h04, 8'h11, "ovf_data");
        rd_chk(1, 5'h10, 8'h01, "ovf_clr");

        // RX held low: framing error with 0x00 delivered
        repeat (100) @(posedge clk);
        #1;
        force_val = 1'b0; force_rx = 1'b1;
        wait_rx(1'b0, 1000, "ferr_wait");
        rd_chk(1, 5'h10, 8'h13, "ferr_status");
        rd_chk(1, 5'h04, 8'h00, "ferr_data");
        force_rx = 1'b0;
        repeat (600) @(posedge clk);
        apb_rd(1, 5'h04, v);

        // Reset in the middle of a frame
        apb_wr(0, 5'h08, 8'h05);
        apb_wr(0, 5'h0C, 8'h03);
        apb_wr(0, 5'h00, 8'h00);
        repeat (200) @(posedge clk);
        #1;
        chk("mid_frame_tx_low", {7'b0, tx[0]}, 8'h00);
        rstn[0] = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_tx", {7'b0, tx[0]}, 8'h01);
        chk("rst_mid_pins", {3'b0, txrdy[0], rxrdy[0], perr[0], ovf[0], ferr[0]}, 8'h10);
        rstn[0] = 1'b1;
        rd_chk(0, 5'h08, 8'h01, "rst_ctrl1");
        rd_chk(0, 5'h0C, 8'h01, "rst_ctrl2");
        rd_chk(0, 5'h10, 8'h01, "rst_status");
        repeat (50) @(posedge clk);
        #1;
        chk("rst_tx_stays_high", {7'b0, tx[0]}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
